// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Used by the top level and by the clear sequencer.
package regfile_pkg;

    localparam int MAX_WR_PORTS = 4;
    localparam int MAX_RD_PORTS = 6;
    localparam int PORT_W       = $clog2(MAX_WR_PORTS);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rfState_t;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } wrWinner_t;

    // hits[p] = write port p is enabled and targets the address being resolved.
    function automatic wrWinner_t winningPort(input logic [MAX_WR_PORTS-1:0] hits);
        wrWinner_t win;
        win.valid = 1'b0;
        win.port  = '0;
        for (int p = 0; p < MAX_WR_PORTS; p++) begin
            if (hits[p] && !win.valid) begin
                win.valid = 1'b1;
                win.port  = PORT_W'(p);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the register file and its users (decode, writeback, debug).
// The register file takes the slave side.
interface regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2
);
    logic [WR_PORTS-1:0]        writeEnable;
    logic [WR_PORTS*ADDR_W-1:0] writeAddress;
    logic [WR_PORTS*DATA_W-1:0] writeData;
    logic [RD_PORTS*ADDR_W-1:0] readAddress;
    logic [RD_PORTS*DATA_W-1:0] readData;
    logic [ADDR_W-1:0]          dbgAddress;
    logic [DATA_W-1:0]          dbgData;
    logic                       ready;
    logic                       writeDropped;

    modport master (
        output writeEnable, writeAddress, writeData, readAddress, dbgAddress,
        input  readData, dbgData, ready, writeDropped
    );

    modport slave (
        input  writeEnable, writeAddress, writeData, readAddress, dbgAddress,
        output readData, dbgData, ready, writeDropped
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then raises ready.
// Also registers the dropped-write indication while not ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              anyWrite,
    output logic              ready,
    output logic              writeDropped,
    output logic              clearActive,
    output logic [ADDR_W-1:0] clearAddr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rfState_t          state;
    rfState_t          stateNext;
    logic [ADDR_W-1:0] clearCount;

    // NOTE: reset here is synchronous, so it is tested inside the clocked block only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clearCount   <= '0;
            ready        <= 1'b0;
            writeDropped <= 1'b0;
        end else begin
            state        <= stateNext;
            if (state == CLEAR) begin
                clearCount <= clearCount + 1'b1;
            end
            ready        <= (stateNext == READY);
            writeDropped <= !ready && anyWrite;
        end
    end

    always_comb begin
        stateNext = state;
        if (state == CLEAR && clearCount == LAST_ADDR) begin
            stateNext = READY;
        end
    end

    // Storage is left alone on edges where reset is held.
    always_comb begin
        clearActive = (state == CLEAR) && reset;
        clearAddr   = clearCount;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with lowest-port write priority,
// optional write-to-read bypass, optional hardwired zero entry and post-reset clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int WR_PORTS       = 2,
    parameter int RD_PORTS       = 2,
    parameter int BYPASS         = 1,
    parameter int ZERO_REG       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic                    ready;
    logic                    clearActive;
    logic [ADDR_W-1:0]       clearAddr;
    logic [MAX_WR_PORTS-1:0] wValid;
    logic [ADDR_W-1:0]       wAddr [MAX_WR_PORTS];
    logic [DATA_W-1:0]       wData [MAX_WR_PORTS];

    regfile_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) clearSeq (
        .clk          (clk),
        .reset        (reset),
        .anyWrite     (|bus.writeEnable),
        .ready        (ready),
        .writeDropped (bus.writeDropped),
        .clearActive  (clearActive),
        .clearAddr    (clearAddr)
    );

    assign bus.ready = ready;

    // Unpack the write ports; a write is live only once ready and, with a
    // hardwired zero entry, only when it does not target entry 0.
    always_comb begin
        wValid = '0;
        for (int p = 0; p < MAX_WR_PORTS; p++) begin
            wAddr[p] = '0;
            wData[p] = '0;
        end
        for (int p = 0; p < WR_PORTS; p++) begin
            wAddr[p]  = bus.writeAddress[p*ADDR_W +: ADDR_W];
            wData[p]  = bus.writeData[p*DATA_W +: DATA_W];
            wValid[p] = bus.writeEnable[p] && ready &&
                        !((ZERO_REG != 0) && (wAddr[p] == '0));
        end
    end

    // NOTE: storage has no reset branch so it can map onto RAM; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (clearActive) begin
            mem[clearAddr] <= '0;
        end else if (reset) begin
            // Highest port first, so the lowest-numbered port lands last and wins a collision.
            for (int p = WR_PORTS - 1; p >= 0; p--) begin
                if (wValid[p]) begin
                    mem[wAddr[p]] <= wData[p];
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
        logic [MAX_WR_PORTS-1:0] hits;
        wrWinner_t               win;
        hits = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            hits[p] = wValid[p] && (wAddr[p] == addr);
        end
        win = winningPort(hits);
        if (!ready || ((ZERO_REG != 0) && (addr == '0))) begin
            return '0;
        end
        if ((BYPASS != 0) && win.valid) begin
            return wData[win.port];
        end
        return mem[addr];
    endfunction

    always_comb begin
        bus.readData = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            bus.readData[r*DATA_W +: DATA_W] = readPort(bus.readAddress[r*ADDR_W +: ADDR_W]);
        end
    end

    // The debug port always shows the stored value, never in-flight write data.
    always_comb begin
        if (!ready || ((ZERO_REG != 0) && (bus.dbgAddress == '0))) begin
            bus.dbgData = '0;
        end else begin
            bus.dbgData = mem[bus.dbgAddress];
        end
    end

endmodule
